// File: rtl/cell_comm_monitor_pkg.sv
// Shared types and constants for the Aurora link statistics monitor.
// Holds the per-link state encoding, the readSelect codes and the
// counter-index constants used by the channel and the top.
package cell_comm_monitor_pkg;

    typedef enum logic [1:0] {
        LINK_DOWN   = 2'd0,
        LINK_IDLE   = 2'd1,
        LINK_ACTIVE = 2'd2,
        LINK_STALE  = 2'd3
    } linkState_e;

    typedef enum logic [1:0] {
        SEL_CRC_FAULTS  = 2'd0,
        SEL_GOOD_FRAMES = 2'd1,
        SEL_LINK_DROPS  = 2'd2,
        SEL_TIMEOUTS    = 2'd3
    } readSel_e;

    // Counter slots; a readSelect code indexes this array directly
    localparam int unsigned CNT_CRC_FAULTS  = 0;
    localparam int unsigned CNT_GOOD_FRAMES = 1;
    localparam int unsigned CNT_LINK_DROPS  = 2;
    localparam int unsigned CNT_TIMEOUTS    = 3;
    localparam int unsigned NUM_COUNTERS    = 4;

endpackage

// File: rtl/cell_comm_link_monitor_channel.sv
// One monitored Aurora link: link state machine, four statistics
// counters with shadow copies, and a sticky fault flag.
// Optional stale-link timer: CELL_COMM_LINK_MONITOR_TIMEOUT_EN.
module cell_comm_link_monitor_channel
    import cell_comm_monitor_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH  = 32,
    parameter int unsigned SATURATE       = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                                         auUserClk,
    input  logic                                         rstN,
    input  logic                                         channelUp,
    input  logic                                         rxTvalid,
    input  logic                                         rxTlast,
    input  logic                                         rxCRCvalid,
    input  logic                                         rxCRCpass,
    input  logic                                         snapshotStrobe,
    input  logic                                         clearStrobe,
    output logic [1:0]                                   linkState,
    output logic [NUM_COUNTERS-1:0][COUNTER_WIDTH-1:0]   shadowCounters,
    output logic                                         faultFlag
);

    linkState_e                                 stateQ;
    logic [NUM_COUNTERS-1:0][COUNTER_WIDTH-1:0] liveCounters;
    logic [NUM_COUNTERS-1:0]                    cntEvent;
    logic                                       frameEnd;
    logic                                       timeoutHit;

    assign frameEnd  = rxTvalid & rxTlast;
    assign linkState = stateQ;

`ifdef CELL_COMM_LINK_MONITOR_TIMEOUT_EN
    localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TIMER_W-1:0] idleTimer;
    logic               timing;

    assign timing     = channelUp & ((stateQ == LINK_IDLE) | (stateQ == LINK_ACTIVE));
    assign timeoutHit = timing & ~frameEnd & (idleTimer == TIMER_W'(TIMEOUT_CYCLES - 1));

    // Idle timer: counts IDLE/ACTIVE cycles, restarts on every frame end
    always_ff @(posedge auUserClk or negedge rstN) begin
        if (!rstN) begin
            idleTimer <= '0;
        end else if (!timing || frameEnd || timeoutHit) begin
            idleTimer <= '0;
        end else begin
            idleTimer <= idleTimer + TIMER_W'(1);
        end
    end
`else
    logic unusedTimeoutCfg;
    assign unusedTimeoutCfg = (TIMEOUT_CYCLES == 0);
    assign timeoutHit       = 1'b0;
`endif

    // Per-counter increment requests for this cycle
    always_comb begin
        cntEvent                  = '0;
        cntEvent[CNT_CRC_FAULTS]  = rxCRCvalid & ~rxCRCpass;
        cntEvent[CNT_GOOD_FRAMES] = rxCRCvalid & rxCRCpass;
        cntEvent[CNT_LINK_DROPS]  = ~channelUp & (stateQ != LINK_DOWN);
        cntEvent[CNT_TIMEOUTS]    = timeoutHit;
    end

    // Link state machine; loss of channelUp wins over every other transition
    always_ff @(posedge auUserClk or negedge rstN) begin
        if (!rstN) begin
            stateQ <= LINK_DOWN;
        end else if (!channelUp) begin
            stateQ <= LINK_DOWN;
        end else begin
            case (stateQ)
                LINK_DOWN: stateQ <= LINK_IDLE;
                LINK_IDLE, LINK_ACTIVE: begin
                    if (frameEnd) begin
                        stateQ <= LINK_ACTIVE;
                    end else if (timeoutHit) begin
                        stateQ <= LINK_STALE;
                    end
                end
                LINK_STALE: begin
                    if (frameEnd) begin
                        stateQ <= LINK_ACTIVE;
                    end
                end
                default: stateQ <= LINK_DOWN;
            endcase
        end
    end

    // Live counters; a clear that coincides with an event restarts at 1
    always_ff @(posedge auUserClk or negedge rstN) begin
        if (!rstN) begin
            liveCounters <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
                if (clearStrobe) begin
                    liveCounters[i] <= COUNTER_WIDTH'(cntEvent[i]);
                end else if (cntEvent[i]) begin
                    if ((SATURATE != 0) && (liveCounters[i] == '1)) begin
                        liveCounters[i] <= liveCounters[i];
                    end else begin
                        liveCounters[i] <= liveCounters[i] + COUNTER_WIDTH'(1);
                    end
                end
            end
        end
    end

    // Shadow copy takes the pre-update live values, so a coincident clear is not seen
    always_ff @(posedge auUserClk or negedge rstN) begin
        if (!rstN) begin
            shadowCounters <= '0;
        end else if (snapshotStrobe) begin
            shadowCounters <= liveCounters;
        end
    end

    // Sticky fault flag: CRC fault, link drop or timeout; clear yields to a coincident event
    always_ff @(posedge auUserClk or negedge rstN) begin
        if (!rstN) begin
            faultFlag <= 1'b0;
        end else begin
            faultFlag <= (faultFlag & ~clearStrobe) | cntEvent[CNT_CRC_FAULTS]
                       | cntEvent[CNT_LINK_DROPS] | cntEvent[CNT_TIMEOUTS];
        end
    end

endmodule

// File: rtl/cell_comm_link_monitor.sv
// Aurora link statistics monitor: one channel instance per link, shared
// snapshot/clear strobes, registered shadow-register read port and a
// registered any-fault summary. Reset asserts asynchronously and is
// released synchronously to auUserClk.
// Optional stale-link timer: CELL_COMM_LINK_MONITOR_TIMEOUT_EN.
module cell_comm_link_monitor
    import cell_comm_monitor_pkg::*;
#(
    parameter int unsigned CHANNEL_COUNT  = 2,
    parameter int unsigned COUNTER_WIDTH  = 32,
    parameter int unsigned SATURATE       = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                                                  auUserClk,
    input  logic                                                  auUserResetN,
    input  logic [CHANNEL_COUNT-1:0]                              channelUp,
    input  logic [CHANNEL_COUNT-1:0]                              rxTvalid,
    input  logic [CHANNEL_COUNT-1:0]                              rxTlast,
    input  logic [CHANNEL_COUNT-1:0]                              rxCRCvalid,
    input  logic [CHANNEL_COUNT-1:0]                              rxCRCpass,
    input  logic                                                  snapshotStrobe,
    input  logic                                                  clearStrobe,
    input  logic                                                  readStrobe,
    input  logic [((CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1)-1:0] readChannel,
    input  logic [1:0]                                            readSelect,
    output logic [COUNTER_WIDTH-1:0]                              readData,
    output logic                                                  readValid,
    output logic [2*CHANNEL_COUNT-1:0]                            linkState,
    output logic                                                  anyFault
);

    logic [1:0]                                 rstSync;
    logic                                       rstN;
    logic [NUM_COUNTERS-1:0][COUNTER_WIDTH-1:0] shadowVals [CHANNEL_COUNT];
    logic [CHANNEL_COUNT-1:0]                   faultFlags;
    logic [COUNTER_WIDTH-1:0]                   readMux;

    // Reset synchroniser: immediate assertion, two-flop release
    always_ff @(posedge auUserClk or negedge auUserResetN) begin
        if (!auUserResetN) begin
            rstSync <= '0;
        end else begin
            rstSync <= {rstSync[0], 1'b1};
        end
    end

    assign rstN = rstSync[1];

    for (genvar g = 0; g < CHANNEL_COUNT; g++) begin : gChannel
        cell_comm_link_monitor_channel #(
            .COUNTER_WIDTH  (COUNTER_WIDTH),
            .SATURATE       (SATURATE),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) uChannel (
            .auUserClk      (auUserClk),
            .rstN           (rstN),
            .channelUp      (channelUp[g]),
            .rxTvalid       (rxTvalid[g]),
            .rxTlast        (rxTlast[g]),
            .rxCRCvalid     (rxCRCvalid[g]),
            .rxCRCpass      (rxCRCpass[g]),
            .snapshotStrobe (snapshotStrobe),
            .clearStrobe    (clearStrobe),
            .linkState      (linkState[2*g +: 2]),
            .shadowCounters (shadowVals[g]),
            .faultFlag      (faultFlags[g])
        );
    end

    // Shadow read mux; indices past the last link read as zero
    always_comb begin
        readMux = '0;
        if (32'(readChannel) < CHANNEL_COUNT) begin
            readMux = shadowVals[readChannel][readSelect];
        end
    end

    // Registered read port; readData holds between reads
    always_ff @(posedge auUserClk or negedge rstN) begin
        if (!rstN) begin
            readData  <= '0;
            readValid <= 1'b0;
        end else begin
            readValid <= readStrobe;
            if (readStrobe) begin
                readData <= readMux;
            end
        end
    end

    // Registered summary of all link fault flags
    always_ff @(posedge auUserClk or negedge rstN) begin
        if (!rstN) begin
            anyFault <= 1'b0;
        end else begin
            anyFault <= |faultFlags;
        end
    end

endmodule

// File: tb/tb_cell_comm_link_monitor.sv
// Bench for cell_comm_link_monitor: a 2-link 32-bit instance plus two
// 3-link 8-bit instances (saturating and wrapping) sharing one stimulus.
// The reference model keeps unbounded event counts per link and derives
// the expected counter width/saturation view only at comparison time.
module tb_cell_comm_link_monitor;

    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       rstN;
    logic [1:0] up, tv, tl, cv, cp;
    logic       snap, clr, rdS;
    logic [1:0] rdCh, rdSel;

    logic [31:0] mRd;  logic mRv; logic [3:0] mLs; logic mAf;
    logic [7:0]  sRd;  logic sRv; logic [5:0] sLs; logic sAf;
    logic [7:0]  wRd;  logic wRv; logic [5:0] wLs; logic wAf;

    always #5 clk = ~clk;

    cell_comm_link_monitor #(
        .CHANNEL_COUNT(2), .COUNTER_WIDTH(32), .SATURATE(1), .TIMEOUT_CYCLES(TO)
    ) uDutMain (
        .auUserClk(clk), .auUserResetN(rstN), .channelUp(up), .rxTvalid(tv), .rxTlast(tl),
        .rxCRCvalid(cv), .rxCRCpass(cp), .snapshotStrobe(snap), .clearStrobe(clr),
        .readStrobe(rdS), .readChannel(rdCh[0]), .readSelect(rdSel), .readData(mRd),
        .readValid(mRv), .linkState(mLs), .anyFault(mAf)
    );

    cell_comm_link_monitor #(
        .CHANNEL_COUNT(3), .COUNTER_WIDTH(8), .SATURATE(1), .TIMEOUT_CYCLES(TO)
    ) uDutSat (
        .auUserClk(clk), .auUserResetN(rstN), .channelUp({1'b0, up}), .rxTvalid({1'b0, tv}),
        .rxTlast({1'b0, tl}), .rxCRCvalid({1'b0, cv}), .rxCRCpass({1'b0, cp}),
        .snapshotStrobe(snap), .clearStrobe(clr), .readStrobe(rdS), .readChannel(rdCh),
        .readSelect(rdSel), .readData(sRd), .readValid(sRv), .linkState(sLs), .anyFault(sAf)
    );

    cell_comm_link_monitor #(
        .CHANNEL_COUNT(3), .COUNTER_WIDTH(8), .SATURATE(0), .TIMEOUT_CYCLES(TO)
    ) uDutWrap (
        .auUserClk(clk), .auUserResetN(rstN), .channelUp({1'b0, up}), .rxTvalid({1'b0, tv}),
        .rxTlast({1'b0, tl}), .rxCRCvalid({1'b0, cv}), .rxCRCpass({1'b0, cp}),
        .snapshotStrobe(snap), .clearStrobe(clr), .readStrobe(rdS), .readChannel(rdCh),
        .readSelect(rdSel), .readData(wRd), .readValid(wRv), .linkState(wLs), .anyFault(wAf)
    );

    // Reference model: counts since last clear, indexed [counter][link]
    longint cnt [4][2];
    longint shd [4][2];
    int     st  [2];
    int     idl [2];
    bit     flg [2];
    bit     anyExp, rvExp;
    longint rdMainRaw, rdSmallRaw;
    int     vectors = 0;
    int     miscompares = 0;

    function automatic longint fit(longint c, int w, bit sat);
        longint mx;
        mx = (longint'(1) << w) - 1;
        if (sat) return (c > mx) ? mx : c;
        return c & mx;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 4; k++) begin
            for (int l = 0; l < 2; l++) begin
                cnt[k][l] = 0;
                shd[k][l] = 0;
            end
        end
        for (int l = 0; l < 2; l++) begin
            st[l] = 0; idl[l] = 0; flg[l] = 0;
        end
        anyExp = 0; rvExp = 0; rdMainRaw = 0; rdSmallRaw = 0;
    endtask

    task automatic modelEdge();
        bit anyNext;
        anyNext = flg[0] | flg[1];
        if (rdS) begin
            rvExp     = 1;
            rdMainRaw = shd[int'(rdSel)][int'(rdCh[0])];
            rdSmallRaw = (rdCh < 2) ? shd[int'(rdSel)][int'(rdCh)] : 0;
        end else begin
            rvExp = 0;
        end
        if (snap) begin
            for (int k = 0; k < 4; k++)
                for (int l = 0; l < 2; l++)
                    shd[k][l] = cnt[k][l];
        end
        for (int l = 0; l < 2; l++) begin
            bit ev [4];
            bit frame;
            int nst;
            frame = tv[l] & tl[l];
            ev[0] = cv[l] & ~cp[l];
            ev[1] = cv[l] & cp[l];
            ev[2] = !up[l] && (st[l] != 0);
            ev[3] = 0;
            nst   = st[l];
            if (!up[l]) nst = 0;
            else if (st[l] == 0) nst = 1;
            else if (frame) nst = 2;
`ifdef CELL_COMM_LINK_MONITOR_TIMEOUT_EN
            else if ((st[l] == 1 || st[l] == 2) && idl[l] == TO - 1) begin
                nst = 3;
                ev[3] = 1;
            end
`endif
            if (up[l] && (st[l] == 1 || st[l] == 2) && !frame && !ev[3]) idl[l]++;
            else idl[l] = 0;
            for (int k = 0; k < 4; k++)
                cnt[k][l] = clr ? longint'(ev[k]) : cnt[k][l] + longint'(ev[k]);
            flg[l] = (clr ? 1'b0 : flg[l]) | ev[0] | ev[2] | ev[3];
            st[l] = nst;
        end
        anyExp = anyNext;
    endtask

    task automatic checkAll();
        logic [3:0] e;
        e = {st[1][1:0], st[0][1:0]};
        check("main_state", mLs, e);
        check("sat_state",  sLs, {2'b00, e});
        check("wrap_state", wLs, {2'b00, e});
        check("main_anyFault", mAf, anyExp);
        check("sat_anyFault",  sAf, anyExp);
        check("wrap_anyFault", wAf, anyExp);
        check("main_readValid", mRv, rvExp);
        check("sat_readValid",  sRv, rvExp);
        check("wrap_readValid", wRv, rvExp);
        check("main_readData", mRd, fit(rdMainRaw, 32, 1));
        check("sat_readData",  sRd, fit(rdSmallRaw, 8, 1));
        check("wrap_readData", wRd, fit(rdSmallRaw, 8, 0));
    endtask

    task automatic step();
        modelEdge();
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic setIdle();
        up = '0; tv = '0; tl = '0; cv = '0; cp = '0;
        snap = 0; clr = 0; rdS = 0; rdCh = '0; rdSel = '0;
    endtask

    task automatic doSnap();
        snap = 1; step(); snap = 0;
    endtask

    task automatic doRead(input logic [1:0] ch, input logic [1:0] sel);
        rdCh = ch; rdSel = sel; rdS = 1;
        step();
        rdS = 0;
    endtask

    initial begin
        rstN = 0;
        setIdle();
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_readData", mRd, 0);
        checkAll();
        rstN = 1;
        repeat (3) step();

        // Link 1: three CRC failures, snapshot, read crcFaults
        up = 2'b10;
        repeat (2) step();
        cv[1] = 1; cp[1] = 0; tv[1] = 1; tl[1] = 1;
        repeat (3) step();
        cv = '0; tv = '0; tl = '0;
        step();
        doSnap();
        doRead(2'd1, 2'd0);
        check("s1_readData", mRd, 3);
        check("s1_readValid", mRv, 1);
        check("s1_anyFault", mAf, 1);
        step();
        check("s1_readValid_low", mRv, 0);
        check("s1_readData_hold", mRd, 3);

        // Clear coinciding with a CRC failure keeps the new event
        clr = 1; cv[1] = 1; cp[1] = 0;
        step();
        clr = 0; cv = '0;
        doSnap();
        doRead(2'd1, 2'd0);
        check("clr_evt_main", mRd, 1);
        check("clr_evt_sat", sRd, 1);

        // Link 0 toggled down/up four times
        clr = 1; step(); clr = 0;
        up[0] = 1; step();
        check("tog_up0", mLs[1:0], 1);
        for (int i = 0; i < 4; i++) begin
            up[0] = 0; step();
            check("tog_down", mLs[1:0], 0);
            up[0] = 1; step();
            check("tog_up", mLs[1:0], 1);
        end
        doSnap();
        doRead(2'd0, 2'd2);
        check("tog_drops", mRd, 4);

        // 300 good frames on link 0: saturate vs wrap at 8 bits
        clr = 1; step(); clr = 0;
        cv[0] = 1; cp[0] = 1;
        repeat (300) step();
        cv = '0; cp = '0;
        doSnap();
        doRead(2'd0, 2'd1);
        check("good_main", mRd, 300);
        check("good_sat", sRd, 255);
        check("good_wrap", wRd, 44);
        doRead(2'd3, 2'd1);
        check("oor_sat", sRd, 0);
        check("oor_wrap", wRd, 0);

        // Stale-link timer on link 0
        up[0] = 0; clr = 1; step(); clr = 0;
        up[0] = 1; step();
        tv[0] = 1; tl[0] = 1; step();
        tv = '0; tl = '0;
        check("to_active", mLs[1:0], 2);
        repeat (99) step();
        check("to_before", mLs[1:0], 2);
        step();
`ifdef CELL_COMM_LINK_MONITOR_TIMEOUT_EN
        check("to_stale", mLs[1:0], 3);
`else
        check("to_nostale", mLs[1:0], 2);
`endif
        doSnap();
        doRead(2'd0, 2'd3);
`ifdef CELL_COMM_LINK_MONITOR_TIMEOUT_EN
        check("to_count", mRd, 1);
`else
        check("to_count", mRd, 0);
`endif
        tv[0] = 1; tl[0] = 1; step();
        tv = '0; tl = '0;
        check("to_recover", mLs[1:0], 2);

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            up    = {($urandom_range(15) != 0), ($urandom_range(15) != 0)};
            tv    = 2'($urandom);
            tl    = 2'($urandom);
            cv    = 2'($urandom);
            cp    = 2'($urandom);
            snap  = ($urandom_range(9) == 0);
            clr   = ($urandom_range(19) == 0);
            rdS   = ($urandom_range(3) == 0);
            rdCh  = 2'($urandom);
            rdSel = 2'($urandom);
            step();
        end

        // Reset asserted while a read is pending
        setIdle();
        up = 2'b11; repeat (3) step();
        cv[0] = 1; step(); cv = '0;
        repeat (2) step();
        doSnap();
        doRead(2'd0, 2'd0);
        step();
        rdS = 1; rdCh = 2'd0; rdSel = 2'd0;
        #3;
        rstN = 0;
        #1;
        check("rst_main_rd", mRd, 0);
        check("rst_main_rv", mRv, 0);
        check("rst_main_ls", mLs, 0);
        check("rst_main_af", mAf, 0);
        check("rst_sat_rd", sRd, 0);
        check("rst_sat_ls", sLs, 0);
        check("rst_wrap_af", wAf, 0);
        @(posedge clk);
        #1;
        check("rst_rv_suppressed", mRv, 0);
        setIdle();
        modelReset();
        rstN = 1;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
